// File: rtl/sdu_pkg.sv
// Shared types and constants for the serial debug unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sdu_pkg;

   // Receiver frame states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4,
      ST_BRK   = 3'd5
   } state_e;

   // Parity modes
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // $clog2 that never returns 0, so it can size a vector for any n >= 0
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sdu_sync_fifo.sv
// Show-ahead synchronous FIFO; head word is registered and held while empty.
// Latency: a word pushed into an empty FIFO is visible on dout/!empty one clk after the push edge.
// Backpressure: push is dropped when full unless a pop occurs in the same cycle; pop on empty is ignored.
// Ports: clk, rstn (async active-low), push/din (write), pop (read),
//        dout (head), empty, full, level (occupancy, one extra bit for full).
module sdu_sync_fifo
   import sdu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    push,
   input  logic [WIDTH-1:0]        din,
   input  logic                    pop,
   output logic [WIDTH-1:0]        dout,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_cnt_q, rd_cnt_q;
   logic [AW:0]      rd_cnt_d, level_d;
   logic [WIDTH-1:0] dout_q, head_d;
   logic             push_acc, pop_acc;

   assign level    = wr_cnt_q - rd_cnt_q;
   assign empty    = (level == '0);
   assign full     = (level == (AW+1)'(DEPTH));
   assign pop_acc  = pop && !empty;
   // a pop in the same cycle frees the slot the push needs
   assign push_acc = push && (!full || pop_acc);
   assign rd_cnt_d = rd_cnt_q + {{AW{1'b0}}, pop_acc};
   assign level_d  = level + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
   assign dout     = dout_q;

   // Next head word: if the new head is the slot being written this cycle,
   // take it straight from din; if the FIFO goes empty, keep the old word.
   always_comb begin
      head_d = dout_q;
      if (level_d != '0) begin
         if (rd_cnt_d == wr_cnt_q) head_d = din;
         else                      head_d = mem[rd_cnt_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_cnt_q[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         dout_q   <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_q + {{AW{1'b0}}, push_acc};
         rd_cnt_q <= rd_cnt_d;
         dout_q   <= head_d;
      end
   end

endmodule

// File: rtl/sdu_uart_rx_fifo.sv
// UART receiver (OVS oversampling, 3-sample majority, optional parity, 1/2 stop bits) with RX FIFO.
// Latency: word on d_rx/vld_rx 2 clks after the last stop-bit voting sample; err_frame/err_parity 1 clk after it, err_ovf 2.
// Backpressure: vld_rx/rdy_rx pop; a good frame arriving with the FIFO full and no same-cycle pop is dropped with err_ovf.
// Ports: clk, rstn (async active-low), rxd (async serial in, idle high),
//        d_rx/vld_rx/rdy_rx (show-ahead FIFO head), level (occupancy),
//        busy (frame in progress), err_frame/err_parity/err_ovf (1-clk pulses).
module sdu_uart_rx_fifo
   import sdu_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVS        = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         rxd,
   output logic [DATA_BITS-1:0]         d_rx,
   output logic                         vld_rx,
   input  logic                         rdy_rx,
   output logic [$clog2(FIFO_DEPTH):0]  level,
   output logic                         busy,
   output logic                         err_frame,
   output logic                         err_parity,
   output logic                         err_ovf
);

   localparam int DIV = CLK_HZ / (BAUD * OVS);
   localparam int DW  = clog2_safe(DIV);
   localparam int SW  = clog2_safe(OVS);

   if (DIV < 1) begin : g_div_chk
      $error("sdu_uart_rx_fifo: CLK_HZ/(BAUD*OVS) must be >= 1");
   end
   if ((OVS < 8) || (OVS % 2 != 0)) begin : g_ovs_chk
      $error("sdu_uart_rx_fifo: OVS must be even and >= 8");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_db_chk
      $error("sdu_uart_rx_fifo: DATA_BITS must be 5..9");
   end
   if ((PARITY != PAR_NONE) && (PARITY != PAR_EVEN) && (PARITY != PAR_ODD)) begin : g_par_chk
      $error("sdu_uart_rx_fifo: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_sb_chk
      $error("sdu_uart_rx_fifo: STOP_BITS must be 1 or 2");
   end

   // ---------------- synchroniser and line-arming ----------------
   logic [1:0] sync_q;
   logic       rxd_s;
   logic [1:0] settle_q;
   logic       armed_q;

   assign rxd_s = sync_q[1];

   // The synchroniser resets to 1, which is not proof of an idle line; only
   // once it has flushed and shows a real high does a falling edge count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q   <= 2'b11;
         settle_q <= 2'd0;
         armed_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rxd};
         if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
         if ((settle_q == 2'd3) && rxd_s) armed_q <= 1'b1;
      end
   end

   // ---------------- free-running oversample tick ----------------
   logic [DW-1:0] div_q;
   logic          tick;

   assign tick = (div_q == DW'(DIV - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + 1'b1;
   end

   // ---------------- frame FSM ----------------
   state_e               state_q;
   logic [SW-1:0]        sub_q;
   logic [3:0]           cnt_q;
   logic [DATA_BITS-1:0] shr_q;
   logic                 samp_a_q, samp_b_q;
   logic                 par_bad_q;
   logic                 busy_q, err_frame_q, err_parity_q, push_req_q;
   logic                 mid, vote, par_x;

   // third voting sample is taken live at OVS/2+1; the other two are stored
   assign mid   = tick && (sub_q == SW'(OVS/2 + 1));
   assign vote  = (samp_a_q & samp_b_q) | (samp_a_q & rxd_s) | (samp_b_q & rxd_s);
   assign par_x = ^{shr_q, vote};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         sub_q        <= '0;
         cnt_q        <= '0;
         shr_q        <= '0;
         samp_a_q     <= 1'b1;
         samp_b_q     <= 1'b1;
         par_bad_q    <= 1'b0;
         busy_q       <= 1'b0;
         err_frame_q  <= 1'b0;
         err_parity_q <= 1'b0;
         push_req_q   <= 1'b0;
      end else begin
         err_frame_q  <= 1'b0;
         err_parity_q <= 1'b0;
         push_req_q   <= 1'b0;

         if (tick && (state_q != ST_IDLE)) begin
            sub_q <= (sub_q == SW'(OVS - 1)) ? '0 : sub_q + 1'b1;
            if (sub_q == SW'(OVS/2 - 1)) samp_a_q <= rxd_s;
            if (sub_q == SW'(OVS/2))     samp_b_q <= rxd_s;
         end

         case (state_q)
            ST_IDLE: begin
               if (tick && !rxd_s && armed_q) begin
                  state_q   <= ST_START;
                  sub_q     <= '0;
                  busy_q    <= 1'b1;
                  par_bad_q <= 1'b0;
               end
            end
            ST_START: begin
               if (mid) begin
                  if (!vote) begin
                     state_q <= ST_DATA;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;   // glitch, silently dropped
                     busy_q  <= 1'b0;
                  end
               end
            end
            ST_DATA: begin
               if (mid) begin
                  shr_q <= {vote, shr_q[DATA_BITS-1:1]};   // LSB arrives first
                  if (cnt_q == 4'(DATA_BITS - 1)) begin
                     cnt_q   <= '0;
                     state_q <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            ST_PAR: begin
               if (mid) begin
                  par_bad_q <= (PARITY == PAR_ODD) ? ~par_x : par_x;
                  state_q   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (mid) begin
                  if (!vote) begin
                     err_frame_q <= 1'b1;
                     state_q     <= ST_BRK;
                  end else if (cnt_q == 4'(STOP_BITS - 1)) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     if (par_bad_q) err_parity_q <= 1'b1;
                     else           push_req_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            ST_BRK: begin
               if (tick && rxd_s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- FIFO and overflow ----------------
   logic fifo_empty, fifo_full, err_ovf_q;

   // Overflow is judged in the push cycle itself, so a pop in that very
   // cycle still makes room for the word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) err_ovf_q <= 1'b0;
      else       err_ovf_q <= push_req_q && fifo_full && !(rdy_rx && vld_rx);
   end

   sdu_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push_req_q),
      .din   (shr_q),
      .pop   (rdy_rx),
      .dout  (d_rx),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (level)
   );

   assign vld_rx     = !fifo_empty;
   assign busy       = busy_q;
   assign err_frame  = err_frame_q;
   assign err_parity = err_parity_q;
   assign err_ovf    = err_ovf_q;

endmodule
